prbs_chk: RTL and testbench

Serial checker for the 4-stage PRBS stream (recurrence r[n] = r[n-4] XOR r[n-3], period 15; seed 1111 gives 1,1,1,1,0,0,0,1,0,0,1,1,0,1,0,…). Sits at the receive end of a PRBS link-test path, after the bit sampler. It self-synchronises to the incoming bit stream, declares lock, then counts bit errors against a free-running local copy of the sequence. It also detects loss of lock.

---
 rtl/prbs_pkg.sv | 25 ++
 rtl/prbs_sat_cnt.sv | 34 +++
 rtl/prbs_chk.sv | 149 ++++++++++++++
 tb/tb_prbs_chk.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the 4-stage PRBS generator/checker pair
// (recurrence r[n] = r[n-4] ^ r[n-3], period 15).
package prbs_pkg;

  localparam int unsigned PRBS_ORDER  = 4;
  localparam int unsigned PRBS_PERIOD = 15;
  localparam logic [PRBS_ORDER-1:0] PRBS_SEED = 4'hF;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // Bit predicted by the recurrence; s[0] is the oldest bit, s[3] the newest.
  function automatic logic prbs_pred(input logic [PRBS_ORDER-1:0] s);
    return s[0] ^ s[1];
  endfunction

  // Advance the LFSR by one bit: shift the predicted bit in at the top.
  function automatic logic [PRBS_ORDER-1:0] prbs_next(input logic [PRBS_ORDER-1:0] s);
    return {prbs_pred(s), s[PRBS_ORDER-1:1]};
  endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating up-counter with synchronous clear. A clear coinciding with an
// increment leaves the count at 1, so the simultaneous event is not lost.
module prbs_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d    = '0;
      cnt_d[0] = inc;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prbs_chk.sv
// Self-synchronising PRBS-4 checker with lock/loss detection and error count.
// Optional bit counter built only when PRBS_CHK_BITCNT_EN is defined.
module prbs_chk
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_THR = 4,
  parameter int unsigned ERR_W    = 16,
  parameter int unsigned BIT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [BIT_W-1:0] bit_cnt
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_THR - 1);
  localparam logic [3:0] WIN_LAST  = 4'(PRBS_PERIOD - 1);

  chk_state_e            state_q, state_d;
  logic [PRBS_ORDER-1:0] hist_q, hist_d;
  logic [PRBS_ORDER-1:0] lfsr_q, lfsr_d;
  logic [1:0]            fill_q, fill_d;
  logic [7:0]            match_q, match_d;
  logic [3:0]            loss_q, loss_d;
  logic [3:0]            good_q, good_d;
  logic                  err_q, err_d;
  logic                  locked_q, locked_d;
  logic                  err_inc;

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    lfsr_d  = lfsr_q;
    fill_d  = fill_q;
    match_d = match_q;
    loss_d  = loss_q;
    good_d  = good_q;
    err_d   = 1'b0;
    err_inc = 1'b0;
    if (din_valid) begin
      // History always tracks the received stream so a lost lock can re-hunt at once.
      hist_d = {din, hist_q[PRBS_ORDER-1:1]};
      case (state_q)
        FILL: begin
          fill_d = fill_q + 2'd1;
          if (fill_q == 2'd3) state_d = HUNT;
        end
        HUNT: begin
          if (hist_q == '0) begin
            match_d = '0;
          end else if (din == prbs_pred(hist_q)) begin
            if (match_q == LOCK_LAST) begin
              state_d = LOCKED;
              lfsr_d  = hist_d;
              match_d = '0;
              loss_d  = '0;
              good_d  = '0;
            end else begin
              match_d = match_q + 8'd1;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // The local LFSR free-runs so a single flipped bit costs exactly one error.
          lfsr_d = prbs_next(lfsr_q);
          if (din != prbs_pred(lfsr_q)) begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            good_d  = '0;
            if (loss_q == LOSS_LAST) begin
              state_d = HUNT;
              match_d = '0;
              loss_d  = '0;
            end else begin
              loss_d = loss_q + 4'd1;
            end
          end else if (good_q == WIN_LAST) begin
            good_d = '0;
            loss_d = '0;
          end else begin
            good_d = good_q + 4'd1;
          end
        end
        default: state_d = FILL;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      hist_q   <= '0;
      lfsr_q   <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      loss_q   <= '0;
      good_q   <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      lfsr_q   <= lfsr_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      loss_q   <= loss_d;
      good_q   <= good_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
  assign err    = err_q;

  prbs_sat_cnt #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_err),
    .inc   (err_inc),
    .cnt   (err_cnt)
  );

`ifdef PRBS_CHK_BITCNT_EN
  logic bit_inc;
  assign bit_inc = din_valid && (state_q == LOCKED);

  prbs_sat_cnt #(.W(BIT_W)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_err),
    .inc   (bit_inc),
    .cnt   (bit_cnt)
  );
`else
  assign bit_cnt = '0;
`endif

endmodule

// File: tb/tb_prbs_chk.sv
// Randomised self-checking bench for prbs_chk against a sequence-level model.
// Two instances share stimulus: ERR_W=16 and ERR_W=4 (for saturation).
module tb_prbs_chk;

  localparam int LOCK_CNT = 8;
  localparam int LOSS_THR = 4;
`ifdef PRBS_CHK_BITCNT_EN
  localparam bit BITCNT_ON = 1'b1;
`else
  localparam bit BITCNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din_valid = 1'b0;
  logic        din = 1'b0;
  logic        clr_err = 1'b0;
  logic        locked, err, locked4, err4;
  logic [15:0] err_cnt;
  logic [3:0]  err_cnt4;
  logic [31:0] bit_cnt, bit_cnt4;

  always #5 clk = ~clk;

  prbs_chk #(.LOCK_CNT(LOCK_CNT), .LOSS_THR(LOSS_THR), .ERR_W(16), .BIT_W(32)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .clr_err(clr_err),
    .locked(locked), .err(err), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  prbs_chk #(.LOCK_CNT(LOCK_CNT), .LOSS_THR(LOSS_THR), .ERR_W(4), .BIT_W(32)) dut4 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .clr_err(clr_err),
    .locked(locked4), .err(err4), .err_cnt(err_cnt4), .bit_cnt(bit_cnt4)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference stream: one period of the recurrence, seeded 1111.
  bit seq[15];
  int gpos = 0;

  task automatic next_bit(output bit b);
    b = seq[gpos % 15];
    gpos++;
  endtask

  // Sequence-level model: mode 0=fill, 1=hunt, 2=locked.
  int      m_mode, m_nrx, m_match, m_loss, m_good;
  bit      rxq[$];   // last 4 received bits, oldest first
  bit      lq[$];    // last 4 bits of the locally expected sequence
  bit      m_locked, m_err;
  int      m_ecnt, m_ecnt4;
  longint  m_bcnt;

  task automatic model_reset();
    m_mode = 0; m_nrx = 0; m_match = 0; m_loss = 0; m_good = 0;
    rxq.delete(); lq.delete();
    m_locked = 0; m_err = 0; m_ecnt = 0; m_ecnt4 = 0; m_bcnt = 0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit c);
    bit e, inc_e, inc_b, allz;
    inc_e = 0; inc_b = 0; m_err = 0;
    if (v) begin
      if (m_mode == 0) begin
        rxq.push_back(d);
        m_nrx++;
        if (m_nrx == 4) m_mode = 1;
      end else if (m_mode == 1) begin
        allz = (rxq[0] | rxq[1] | rxq[2] | rxq[3]) == 1'b0;
        e = rxq[0] ^ rxq[1];
        rxq.push_back(d); void'(rxq.pop_front());
        if (allz) m_match = 0;
        else if (d == e) begin
          m_match++;
          if (m_match == LOCK_CNT) begin
            m_mode = 2; m_match = 0; m_loss = 0; m_good = 0;
            lq = rxq;
          end
        end else m_match = 0;
      end else begin
        e = lq[0] ^ lq[1];
        lq.push_back(e); void'(lq.pop_front());
        rxq.push_back(d); void'(rxq.pop_front());
        inc_b = 1;
        if (d != e) begin
          m_err = 1; inc_e = 1; m_good = 0; m_loss++;
          if (m_loss == LOSS_THR) begin
            m_mode = 1; m_match = 0; m_loss = 0;
          end
        end else begin
          m_good++;
          if (m_good == 15) begin m_good = 0; m_loss = 0; end
        end
      end
    end
    m_locked = (m_mode == 2);
    if (c) begin
      m_ecnt = int'(inc_e); m_ecnt4 = int'(inc_e); m_bcnt = longint'(inc_b);
    end else begin
      if (inc_e && m_ecnt < 65535) m_ecnt++;
      if (inc_e && m_ecnt4 < 15) m_ecnt4++;
      if (inc_b && m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
    end
  endtask

  task automatic compare_all();
    chk("locked", locked, m_locked);
    chk("err", err, m_err);
    chk("err_cnt", err_cnt, m_ecnt);
    chk("bit_cnt", bit_cnt, BITCNT_ON ? m_bcnt : 0);
    chk("locked4", locked4, m_locked);
    chk("err4", err4, m_err);
    chk("err_cnt4", err_cnt4, m_ecnt4);
    chk("bit_cnt4", bit_cnt4, BITCNT_ON ? m_bcnt : 0);
  endtask

  task automatic cycle(input bit v, input bit d, input bit c);
    @(negedge clk);
    din_valid = v; din = d; clr_err = c;
    model_step(v, d, c);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Reset is raised between edges to confirm it acts without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1; din_valid = 1'b0; clr_err = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit b, seen, flip;
    int at, nv;
    for (int i = 0; i < 4; i++) seq[i] = 1'b1;
    for (int i = 4; i < 15; i++) seq[i] = seq[i-4] ^ seq[i-3];

    do_reset();
    $display("reset: outputs checked");

    // Clean stream: lock on bit 12, then 100 locked bits.
    seen = 0; at = 0;
    for (int i = 1; i <= 112; i++) begin
      next_bit(b); cycle(1, b, 0);
      if (!seen && locked) begin seen = 1; at = i; end
    end
    chk("lock_bit", at, 12);
    chk("a_err_cnt", err_cnt, 0);
    chk("a_bit_cnt", bit_cnt, BITCNT_ON ? 100 : 0);
    $display("clean stream: locked at bit %0d", at);

    // Single flipped bit while locked.
    for (int i = 1; i <= 60; i++) begin
      next_bit(b); cycle(1, b ^ (i == 40), 0);
    end
    chk("b_err_cnt", err_cnt, 1);
    chk("b_locked", locked, 1);
    $display("single error: err_cnt=%0d", err_cnt);

    // Four errors inside ten bits drop lock; clean stream relocks.
    for (int i = 0; i < 10; i++) begin
      flip = (i == 0) || (i == 3) || (i == 6) || (i == 9);
      next_bit(b); cycle(1, b ^ flip, 0);
    end
    chk("c_locked", locked, 0);
    chk("c_err_cnt", err_cnt, 5);
    seen = 0;
    for (int i = 1; i <= 30; i++) begin
      next_bit(b); cycle(1, b, 0);
      if (locked) seen = 1;
    end
    chk("c_relock", seen, 1);
    $display("loss of lock: relocked=%0d", seen);

    // Twenty isolated errors: 4-bit counter saturates.
    for (int i = 0; i < 400; i++) begin
      next_bit(b); cycle(1, b ^ (i % 20 == 10), 0);
    end
    chk("d_sat4", err_cnt4, 15);
    chk("d_err_cnt", err_cnt, 25);
    chk("d_locked", locked, 1);
    $display("saturation: err_cnt4=%0d err_cnt=%0d", err_cnt4, err_cnt);

    // Clear coinciding with an error keeps that error.
    next_bit(b); cycle(1, ~b, 1);
    chk("e_clr_err", err_cnt, 1);
    chk("e_clr_err4", err_cnt4, 1);
    for (int i = 0; i < 20; i++) begin next_bit(b); cycle(1, b, 0); end
    next_bit(b); cycle(1, b, 1);
    chk("e_clr_clean", err_cnt, 0);
    $display("clear: err_cnt=%0d", err_cnt);

    // Random valid gaps, sparse errors and clears.
    for (int i = 0; i < 400; i++) begin
      bit v, c;
      v = 1'($urandom % 2);
      c = ($urandom % 100) == 0;
      flip = ($urandom % 50) == 0;
      if (v) next_bit(b); else b = 1'($urandom % 2);
      cycle(v, b ^ flip, c);
    end
    for (int i = 0; i < 60 && !locked; i++) begin next_bit(b); cycle(1, b, 0); end
    chk("f_locked_pre_rst", locked, 1);
    do_reset();
    nv = 0; at = 0;
    for (int i = 0; i < 400 && at == 0; i++) begin
      bit v;
      v = 1'($urandom % 2);
      if (v) begin next_bit(b); nv++; end else b = 1'b0;
      cycle(v, b, 0);
      if (locked) at = nv;
    end
    chk("f_relock_bits", at, 4 + LOCK_CNT);
    $display("reset mid-lock: relocked after %0d valid bits", at);

    // All-zero stream never locks.
    do_reset();
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(1, 0, 0);
      if (locked) seen = 1;
    end
    chk("g_zero_lock", seen, 0);
    chk("g_zero_err", err_cnt, 0);
    $display("zero stream: locked seen=%0d", seen);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
